// File: rtl/cv32e40p_ecc_err_ctrl.sv
// rtl/cv32e40p_ecc_err_ctrl.sv - parity error arbiter with report/recover handshake
// Optional saturating error counter enabled by CV32E40P_ECC_ERR_CNT_EN.
module cv32e40p_ecc_err_ctrl #(
  parameter int NUM_SRC   = 8,
  parameter int CNT_WIDTH = 8,
  localparam int ID_W     = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   err_i,
  output logic                 irq_o,
  output logic                 err_valid_o,
  output logic [ID_W-1:0]      err_id_o,
  input  logic                 irq_ack_i,
  output logic                 recover_req_o,
  input  logic                 recover_done_i,
  output logic                 recover_fail_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  input  logic                 clear_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REPORT,
    S_RECOVER,
    S_SETTLE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] err_q, err_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               fail_q, fail_d;
  logic               ovf_q, ovf_d;

  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] grant_mask;
  logic               grant;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    scan_idx;
  logic               refail;

  assign evt    = err_i & ~err_q;
  assign err_d  = err_i;
  assign refail = (state_q == S_SETTLE) && err_i[id_q];

  // Round-robin: scan from last_q+1 upward, wrapping, first pending source wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      scan_idx = ID_W'((int'(last_q) + i) % NUM_SRC);
      if (!win_found && pend_q[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  assign grant      = (state_q == S_IDLE) && win_found;
  assign grant_mask = grant ? (NUM_SRC'(1) << win_id) : '0;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          id_d    = win_id;
          last_d  = win_id;
          state_d = S_REPORT;
        end
      end
      S_REPORT:  if (irq_ack_i)      state_d = S_RECOVER;
      S_RECOVER: if (recover_done_i) state_d = S_SETTLE;
      S_SETTLE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // New events are ORed in after the grant clear so a same-cycle event keeps its bit.
  always_comb begin
    pend_d = (pend_q & ~grant_mask) | evt;
    if (refail) begin
      pend_d[id_q] = 1'b1;
    end
  end

  always_comb begin
    fail_d = fail_q | refail;
    ovf_d  = ovf_q | (|(evt & pend_q & ~grant_mask));
    if (clear_i) begin
      fail_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= '0;
      pend_q  <= '0;
      last_q  <= ID_W'(NUM_SRC - 1);
      id_q    <= '0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      id_q    <= id_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef CV32E40P_ECC_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (grant && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  assign irq_o          = (state_q == S_REPORT);
  assign err_valid_o    = (state_q == S_REPORT) || (state_q == S_RECOVER);
  assign recover_req_o  = (state_q == S_RECOVER);
  assign err_id_o       = id_q;
  assign recover_fail_o = fail_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_cv32e40p_ecc_err_ctrl.sv
// tb/tb_cv32e40p_ecc_err_ctrl.sv - directed self-checking bench for cv32e40p_ecc_err_ctrl
module tb_cv32e40p_ecc_err_ctrl;

`ifdef CV32E40P_ECC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_i;
  logic       irq_o;
  logic       err_valid_o;
  logic [2:0] err_id_o;
  logic       irq_ack_i;
  logic       recover_req_o;
  logic       recover_done_i;
  logic       recover_fail_o;
  logic       overflow_o;
  logic [1:0] err_cnt_o;
  logic       clear_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_ecc_err_ctrl #(.NUM_SRC(8), .CNT_WIDTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .err_i          (err_i),
    .irq_o          (irq_o),
    .err_valid_o    (err_valid_o),
    .err_id_o       (err_id_o),
    .irq_ack_i      (irq_ack_i),
    .recover_req_o  (recover_req_o),
    .recover_done_i (recover_done_i),
    .recover_fail_o (recover_fail_o),
    .overflow_o     (overflow_o),
    .err_cnt_o      (err_cnt_o),
    .clear_i        (clear_i)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] cnt_exp(input int n);
    if (!CNT_EN) return 2'd0;
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic test_reset;
    rst = 1'b1; err_i = '0; irq_ack_i = 1'b0; recover_done_i = 1'b0; clear_i = 1'b0;
    tick(2);
    rst = 1'b0;
    checks++;
    if ({irq_o, err_valid_o, recover_req_o, recover_fail_o, overflow_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000",
                         {irq_o, err_valid_o, recover_req_o, recover_fail_o, overflow_o});
    end
    checks++;
    if (err_id_o !== 3'd0 || err_cnt_o !== 2'd0) begin
      errors++; $display("FAIL reset_id_cnt: got id=%0d cnt=%0d expected 0/0", err_id_o, err_cnt_o);
    end
  endtask

  task automatic test_single;
    err_i = 8'h08;
    tick(1);
    err_i = 8'h00;
    tick(1);
    checks++;
    if (irq_o !== 1'b1 || err_id_o !== 3'd3 || err_valid_o !== 1'b1 || recover_req_o !== 1'b0) begin
      errors++; $display("FAIL single_report: got irq=%b id=%0d valid=%b req=%b expected 1/3/1/0",
                         irq_o, err_id_o, err_valid_o, recover_req_o);
    end
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0 || recover_req_o !== 1'b1 || err_valid_o !== 1'b1) begin
      errors++; $display("FAIL single_recover: got irq=%b req=%b valid=%b expected 0/1/1",
                         irq_o, recover_req_o, err_valid_o);
    end
    recover_done_i = 1'b1;
    tick(1);
    recover_done_i = 1'b0;
    checks++;
    if (recover_req_o !== 1'b0 || err_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_settle: got req=%b valid=%b expected 0/0", recover_req_o, err_valid_o);
    end
    tick(1);
    checks++;
    if (irq_o !== 1'b0 || err_cnt_o !== cnt_exp(1) || recover_fail_o !== 1'b0) begin
      errors++; $display("FAIL single_done: got irq=%b cnt=%0d fail=%b expected 0/%0d/0",
                         irq_o, err_cnt_o, recover_fail_o, cnt_exp(1));
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] order [5];
    order = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd5};
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    irq_ack_i = 1'b1; recover_done_i = 1'b1;
    err_i = 8'h62;
    tick(1);
    err_i = 8'h00;
    for (int g = 0; g < 5; g++) begin
      if (g == 3) begin
        tick(3);
        err_i = 8'h21;
        tick(1);
        err_i = 8'h00;
        tick(1);
      end else if (g > 0) begin
        tick(4);
      end else begin
        tick(1);
      end
      checks++;
      if (irq_o !== 1'b1 || err_id_o !== order[g]) begin
        errors++; $display("FAIL rr_grant%0d: got irq=%b id=%0d expected 1/%0d", g, irq_o, err_id_o, order[g]);
      end
    end
    tick(3);
    irq_ack_i = 1'b0; recover_done_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0 || err_valid_o !== 1'b0 || err_cnt_o !== cnt_exp(5)) begin
      errors++; $display("FAIL rr_saturate: got irq=%b valid=%b cnt=%0d expected 0/0/%0d",
                         irq_o, err_valid_o, err_cnt_o, cnt_exp(5));
    end
  endtask

  task automatic test_failed_recovery;
    err_i = 8'h04;
    tick(2);
    checks++;
    if (irq_o !== 1'b1 || err_id_o !== 3'd2) begin
      errors++; $display("FAIL fail_grant1: got irq=%b id=%0d expected 1/2", irq_o, err_id_o);
    end
    irq_ack_i = 1'b1; tick(1); irq_ack_i = 1'b0;
    recover_done_i = 1'b1; tick(1); recover_done_i = 1'b0;
    tick(1);
    checks++;
    if (recover_fail_o !== 1'b1) begin
      errors++; $display("FAIL fail_sticky_set: got %b expected 1", recover_fail_o);
    end
    err_i = 8'h00;
    tick(1);
    checks++;
    if (irq_o !== 1'b1 || err_id_o !== 3'd2) begin
      errors++; $display("FAIL fail_grant2: got irq=%b id=%0d expected 1/2", irq_o, err_id_o);
    end
    irq_ack_i = 1'b1; tick(1); irq_ack_i = 1'b0;
    recover_done_i = 1'b1; tick(1); recover_done_i = 1'b0;
    tick(1);
    checks++;
    if (recover_fail_o !== 1'b1 || irq_o !== 1'b0 || err_cnt_o !== cnt_exp(7)) begin
      errors++; $display("FAIL fail_hold: got fail=%b irq=%b cnt=%0d expected 1/0/%0d",
                         recover_fail_o, irq_o, err_cnt_o, cnt_exp(7));
    end
    clear_i = 1'b1; tick(1); clear_i = 1'b0;
    checks++;
    if (recover_fail_o !== 1'b0 || err_cnt_o !== 2'd0) begin
      errors++; $display("FAIL fail_clear: got fail=%b cnt=%0d expected 0/0", recover_fail_o, err_cnt_o);
    end
  endtask

  task automatic test_overflow;
    irq_ack_i = 1'b1; recover_done_i = 1'b1;
    err_i = 8'h40; tick(1); err_i = 8'h00;
    tick(4);
    irq_ack_i = 1'b0; recover_done_i = 1'b0;
    err_i = 8'h90; tick(1); err_i = 8'h00;
    tick(1);
    checks++;
    if (irq_o !== 1'b1 || err_id_o !== 3'd7 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_pre: got irq=%b id=%0d ovf=%b expected 1/7/0", irq_o, err_id_o, overflow_o);
    end
    err_i = 8'h10; tick(1); err_i = 8'h00;
    checks++;
    if (overflow_o !== 1'b1 || irq_o !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got ovf=%b irq=%b expected 1/1", overflow_o, irq_o);
    end
    irq_ack_i = 1'b1; recover_done_i = 1'b1;
    tick(4);
    checks++;
    if (irq_o !== 1'b1 || err_id_o !== 3'd4) begin
      errors++; $display("FAIL ovf_next: got irq=%b id=%0d expected 1/4", irq_o, err_id_o);
    end
    tick(3);
    irq_ack_i = 1'b0; recover_done_i = 1'b0;
    tick(2);
    checks++;
    if (irq_o !== 1'b0 || err_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_idle: got irq=%b valid=%b ovf=%b expected 0/0/1", irq_o, err_valid_o, overflow_o);
    end
    clear_i = 1'b1; tick(1); clear_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0 || err_cnt_o !== 2'd0) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d expected 0/0", overflow_o, err_cnt_o);
    end
  endtask

  task automatic test_clear_with_grant;
    err_i = 8'h02; tick(1); err_i = 8'h00;
    clear_i = 1'b1; tick(1); clear_i = 1'b0;
    checks++;
    if (irq_o !== 1'b1 || err_id_o !== 3'd1 || err_cnt_o !== 2'd0) begin
      errors++; $display("FAIL clear_grant: got irq=%b id=%0d cnt=%0d expected 1/1/0", irq_o, err_id_o, err_cnt_o);
    end
    irq_ack_i = 1'b1; recover_done_i = 1'b1;
    tick(3);
    irq_ack_i = 1'b0; recover_done_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0 || err_valid_o !== 1'b0 || err_cnt_o !== 2'd0) begin
      errors++; $display("FAIL clear_after: got irq=%b valid=%b cnt=%0d expected 0/0/0", irq_o, err_valid_o, err_cnt_o);
    end
  endtask

  task automatic test_mid_reset;
    int irq_seen;
    err_i = 8'h06; tick(1); err_i = 8'h00;
    tick(1);
    irq_ack_i = 1'b1; tick(1); irq_ack_i = 1'b0;
    checks++;
    if (recover_req_o !== 1'b1 || err_cnt_o !== cnt_exp(1)) begin
      errors++; $display("FAIL midrst_pre: got req=%b cnt=%0d expected 1/%0d", recover_req_o, err_cnt_o, cnt_exp(1));
    end
    rst = 1'b1; tick(1); rst = 1'b0;
    checks++;
    if ({irq_o, err_valid_o, recover_req_o, recover_fail_o, overflow_o} !== 5'b0 ||
        err_id_o !== 3'd0 || err_cnt_o !== 2'd0) begin
      errors++; $display("FAIL midrst_outs: got flags=%b id=%0d cnt=%0d expected 00000/0/0",
                         {irq_o, err_valid_o, recover_req_o, recover_fail_o, overflow_o}, err_id_o, err_cnt_o);
    end
    irq_seen = 0;
    recover_done_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (irq_o === 1'b1 || recover_req_o === 1'b1) irq_seen++;
    end
    recover_done_i = 1'b0;
    checks++;
    if (irq_seen !== 0) begin
      errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", irq_seen);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_failed_recovery;
    test_overflow;
    test_clear_with_grant;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
